// File: rtl/rvvi_retire_sequencer.sv
// rvvi_retire_sequencer: folds a multi-hart, multi-slot retirement trace into
// one in-order stream of samples for a coverage sampler. Each cycle, every
// valid lane is written into a shared FIFO in lane order. If the FIFO cannot
// hold the whole group, the group is dropped and counted.
module rvvi_retire_sequencer #(
    parameter int NHART  = 1,
    parameter int RETIRE = 1,
    parameter int ILEN   = 32,
    parameter int DEPTH  = 8,
    localparam int N     = NHART * RETIRE,
    localparam int HW    = (NHART > 1) ? $clog2(NHART) : 1,
    localparam int SW    = (RETIRE > 1) ? $clog2(RETIRE) : 1,
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      in_valid,
    input  logic [N*ILEN-1:0] in_insn,
    input  logic [N-1:0]      in_trap,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ILEN-1:0]   out_insn,
    output logic              out_compressed,
    output logic              out_trap,
    output logic [HW-1:0]     out_hart,
    output logic [SW-1:0]     out_slot,
    output logic              overflow,
    output logic [15:0]       drop_count,
    output logic [OW-1:0]     occupancy
);

    typedef struct packed {
        logic [ILEN-1:0] insn;   // already trimmed to 16 bits when compressed
        logic            trap;
        logic [HW-1:0]   hart;
        logic [SW-1:0]   slot;
    } entry_t;

    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     drop_q, drop_d;

    logic [OW-1:0]   cnt;
    logic [PW-1:0]   lane_off [N];
    logic [PW-1:0]   wr_idx   [N];
    entry_t          lane_entry [N];
    logic            pop;
    logic [OW-1:0]   free;
    logic            accept;
    logic [16:0]     drop_sum;

    // Per-lane entry formatting: trim compressed instructions and tag the lane's hart/slot.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_entry[i].insn = in_insn[i*ILEN +: ILEN];
            if (in_insn[i*ILEN +: 2] != 2'b11) begin
                lane_entry[i].insn = {{(ILEN-16){1'b0}}, in_insn[i*ILEN +: 16]};
            end
            lane_entry[i].trap = in_trap[i];
            lane_entry[i].hart = HW'(i / RETIRE);
            lane_entry[i].slot = SW'(i % RETIRE);
        end
    end

    // Running popcount: each valid lane's slot offset is the number of valid lanes below it.
    always_comb begin
        // NOTE: blocking assignments here make cnt a running sum across loop
        // iterations; in always_comb this is pure logic, not state.
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            lane_off[i] = cnt[PW-1:0];
            wr_idx[i]   = wr_ptr_q + cnt[PW-1:0];
            if (in_valid[i]) begin
                cnt = cnt + 1'b1;
            end
        end
    end

    // Admission control and next-state for pointers, occupancy and drop accounting.
    always_comb begin
        pop      = out_valid && out_ready;
        free     = DEPTH_W - occ_q + OW'(pop);
        accept   = (cnt <= free);
        drop_sum = {1'b0, drop_q} + 17'(cnt);

        wr_ptr_d = wr_ptr_q + (accept ? cnt[PW-1:0] : '0);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_d    = occ_q + (accept ? cnt : '0) - OW'(pop);
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (!accept) begin
            ovf_d  = 1'b1;
            drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Control state; reset wins over any push or pop on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values regardless of block order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // FIFO storage: write every valid lane of an accepted group at its offset slot.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; occupancy alone decides
        // which entries are meaningful, so clearing the array buys nothing.
        if (!reset && accept) begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[i]) begin
                    mem_q[wr_idx[i]] <= lane_entry[i];
                end
            end
        end
    end

    // Outputs come only from registered state, so there is no in_* to out_* path.
    always_comb begin
        out_valid      = (occ_q != '0);
        out_insn       = mem_q[rd_ptr_q].insn;
        out_compressed = (mem_q[rd_ptr_q].insn[1:0] != 2'b11);
        out_trap       = mem_q[rd_ptr_q].trap;
        out_hart       = mem_q[rd_ptr_q].hart;
        out_slot       = mem_q[rd_ptr_q].slot;
        overflow       = ovf_q;
        drop_count     = drop_q;
        occupancy      = occ_q;
    end

endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// Self-checking bench for rvvi_retire_sequencer (NHART=1, RETIRE=2, DEPTH=4).
// A scoreboard queue holds the expected samples. Entries are pushed when a
// group is admitted and popped when the bench accepts the head.
module tb_rvvi_retire_sequencer;

    localparam int NHART  = 1;
    localparam int RETIRE = 2;
    localparam int ILEN   = 32;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [63:0] in_insn;
    logic [1:0]  in_trap;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic        out_compressed;
    logic        out_trap;
    logic        out_hart;
    logic        out_slot;
    logic        overflow;
    logic [15:0] drop_count;
    logic [2:0]  occupancy;

    typedef struct {
        logic [31:0] insn;
        logic        comp;
        logic        trap;
        logic        slot;
    } exp_t;

    exp_t sb[$];
    int   m_drops;
    logic m_ovf;
    int   tests_run;
    int   tests_failed;

    rvvi_retire_sequencer #(
        .NHART (NHART),
        .RETIRE(RETIRE),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_insn       (in_insn),
        .in_trap       (in_trap),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_insn      (out_insn),
        .out_compressed(out_compressed),
        .out_trap      (out_trap),
        .out_hart      (out_hart),
        .out_slot      (out_slot),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    // One clock of stimulus. State and head are compared against the model,
    // then the model is advanced to what the next edge should produce.
    task automatic step(input logic rst, input logic [1:0] v, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] tr, input logic rdy);
        int          k;
        int          free;
        bit          pop;
        exp_t        e;
        logic [31:0] x;
        @(negedge clk);
        reset = rst; in_valid = v; in_insn = {i1, i0}; in_trap = tr; out_ready = rdy;
        #1;
        tests_run++;
        if (out_valid !== (sb.size() != 0)) begin
            tests_failed++;
            $display("FAIL out_valid: got %b expected %b", out_valid, sb.size() != 0);
        end
        tests_run++;
        if (occupancy !== 3'(sb.size())) begin
            tests_failed++;
            $display("FAIL occupancy: got %0d expected %0d", occupancy, sb.size());
        end
        tests_run++;
        if (overflow !== m_ovf || drop_count !== 16'(m_drops)) begin
            tests_failed++;
            $display("FAIL drop_state: got ovf=%b cnt=%0d expected ovf=%b cnt=%0d",
                     overflow, drop_count, m_ovf, m_drops);
        end
        if (sb.size() != 0) begin
            e = sb[0];
            tests_run++;
            if (out_insn !== e.insn || out_compressed !== e.comp || out_trap !== e.trap ||
                out_slot !== e.slot || out_hart !== 1'b0) begin
                tests_failed++;
                $display("FAIL head: got insn=%h c=%b t=%b h=%b s=%b expected insn=%h c=%b t=%b h=0 s=%b",
                         out_insn, out_compressed, out_trap, out_hart, out_slot,
                         e.insn, e.comp, e.trap, e.slot);
            end
        end
        if (rst) begin
            sb.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            pop = rdy && (sb.size() != 0);
            if (pop) void'(sb.pop_front());
            k    = int'(v[0]) + int'(v[1]);
            free = DEPTH - sb.size();
            if (k <= free) begin
                for (int l = 0; l < 2; l++) begin
                    if (v[l]) begin
                        x      = (l == 0) ? i0 : i1;
                        e.comp = (x[1:0] != 2'b11);
                        e.insn = e.comp ? {16'h0000, x[15:0]} : x;
                        e.trap = tr[l];
                        e.slot = 1'(l);
                        sb.push_back(e);
                    end
                end
            end else begin
                m_ovf   = 1'b1;
                m_drops = (m_drops + k > 65535) ? 65535 : m_drops + k;
            end
        end
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int c = 0; c < n; c++) step(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, rdy);
    endtask

    task automatic test_reset();
        step(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_ordering();
        step(1'b0, 2'b11, 32'h0050_0093, 32'h0000_4501, 2'b00, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_insn !== 32'h0050_0093 || out_slot !== 1'b0 || out_compressed !== 1'b0) begin
            tests_failed++;
            $display("FAIL order_first: got v=%b insn=%h s=%b c=%b expected v=1 insn=00500093 s=0 c=0",
                     out_valid, out_insn, out_slot, out_compressed);
        end
        step(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_insn !== 32'h0000_4501 || out_slot !== 1'b1 || out_compressed !== 1'b1) begin
            tests_failed++;
            $display("FAIL order_second: got v=%b insn=%h s=%b c=%b expected v=1 insn=00004501 s=1 c=1",
                     out_valid, out_insn, out_slot, out_compressed);
        end
        idle(1'b1, 2);
    endtask

    task automatic test_trim();
        step(1'b0, 2'b01, 32'hDEAD_8082, 32'h0, 2'b01, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (out_insn !== 32'h0000_8082 || out_compressed !== 1'b1 || out_trap !== 1'b1) begin
            tests_failed++;
            $display("FAIL trim: got insn=%h c=%b t=%b expected insn=00008082 c=1 t=1",
                     out_insn, out_compressed, out_trap);
        end
        idle(1'b1, 2);
    endtask

    task automatic test_overflow_and_pushpop();
        step(1'b0, 2'b11, 32'h1111_1113, 32'h2222_2223, 2'b00, 1'b0);
        step(1'b0, 2'b11, 32'h3333_3333, 32'h0000_4444, 2'b10, 1'b0);
        step(1'b0, 2'b11, 32'h5555_5553, 32'h6666_6663, 2'b00, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (occupancy !== 3'd4 || overflow !== 1'b1 || drop_count !== 16'd2 || out_insn !== 32'h1111_1113) begin
            tests_failed++;
            $display("FAIL overflow: got occ=%0d ovf=%b cnt=%0d head=%h expected occ=4 ovf=1 cnt=2 head=11111113",
                     occupancy, overflow, drop_count, out_insn);
        end
        // Full FIFO with a same-cycle pop has room for exactly one entry.
        step(1'b0, 2'b01, 32'h7777_7777, 32'h0, 2'b00, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (occupancy !== 3'd4 || drop_count !== 16'd2 || out_insn !== 32'h2222_2223) begin
            tests_failed++;
            $display("FAIL push_pop_full: got occ=%0d cnt=%0d head=%h expected occ=4 cnt=2 head=22222223",
                     occupancy, drop_count, out_insn);
        end
        idle(1'b1, 5);
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 2'b01, 32'h0000_1003 + 32'(n << 8), 32'h0, 2'b00, 1'b1);
            step(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
        end
        @(posedge clk); #1;
        tests_run++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_empty: got occ=%0d v=%b expected occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 2'b11, 32'hAAAA_0003, 32'hBBBB_0003, 2'b00, 1'b0);
        step(1'b0, 2'b11, 32'hCCCC_0003, 32'hDDDD_0003, 2'b00, 1'b0);
        step(1'b0, 2'b11, 32'hEEEE_0003, 32'hFFFF_0003, 2'b00, 1'b0);
        step(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (occupancy !== 3'd3 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: got occ=%0d ovf=%b expected occ=3 ovf=1", occupancy, overflow);
        end
        step(1'b1, 2'b11, 32'h1234_5673, 32'h0000_0001, 2'b11, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (occupancy !== 3'd0 || overflow !== 1'b0 || drop_count !== 16'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got occ=%0d ovf=%b cnt=%0d v=%b expected all 0",
                     occupancy, overflow, drop_count, out_valid);
        end
        idle(1'b1, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        for (int c = 0; c < 200; c++) begin
            a = $urandom;
            b = $urandom;
            step(1'b0, 2'($urandom_range(0, 3)), a, b, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(1'b1, 6);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; m_drops = 0; m_ovf = 1'b0;
        reset = 1'b1; in_valid = '0; in_insn = '0; in_trap = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_ordering();
        test_trim();
        test_overflow_and_pushpop();
        test_wrap();
        test_reset_midstream();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
